banked_ram: RTL

BANKED_RAM -- requirements
Module: banked_ram

---
 rtl/banked_ram_if.sv | 11 +
 rtl/banked_ram.sv | 120 ++++++++++++
 2 files changed

// File: rtl/banked_ram_if.sv
// Byte-wide memory-mapped bus shared by the CPU-side and high-page ports of banked_ram.
interface Bus_if;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        read_en;
    logic        write_en;
    logic [7:0]  rdata;

    modport Peripheral_side (input addr, wdata, read_en, write_en, output rdata);
    modport Cpu_side        (output addr, wdata, read_en, write_en, input rdata);
endinterface

// File: rtl/banked_ram.sv
// Banked work RAM (C000..DFFF + echo) and HRAM (FF80..) with an SVBK bank select at FF70
// and a post-reset fill sequencer that writes FILL_VALUE through all of both memories.
module banked_ram #(
    parameter int         NUM_BANKS      = 8,
    parameter int         HRAM_LEN       = 127,
    parameter bit         CLEAR_ON_RESET = 1'b1,
    parameter logic [7:0] FILL_VALUE     = 8'h00
) (
    input  logic    clk,
    input  logic    reset,
    Bus_if.Peripheral_side bus,
    Bus_if.Peripheral_side hram_bus,
    output logic    busy
);

    localparam int BANK_BITS  = $clog2(NUM_BANKS);
    localparam int WRAM_DEPTH = NUM_BANKS * 4096;
    localparam int CNT_W      = $clog2(WRAM_DEPTH);
    localparam int HRAM_AW    = (HRAM_LEN > 1) ? $clog2(HRAM_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WRAM_DEPTH - 1);

    typedef enum logic {CLEAR, IDLE} fill_state_e;
    localparam fill_state_e RESET_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;

    fill_state_e state, state_next;
    logic [CNT_W-1:0]     cnt;
    logic [2:0]           svbk;
    logic                 fill_hram;

    logic [7:0] wram [WRAM_DEPTH];
    logic [7:0] hram [HRAM_LEN];

    // ---------------- address decode ----------------
    logic                 wram_sel, hram_sel, svbk_sel;
    logic [BANK_BITS-1:0] eff_bank, wram_bank;
    logic [CNT_W-1:0]     wram_idx;
    logic [HRAM_AW-1:0]   hram_idx;
    logic                 unused_wdata_hi;

    // Echo space E000..FDFF is addr-0x2000, which leaves bits [12:0] untouched,
    // so bit 12 alone picks fixed bank 0 versus the switchable bank.
    always_comb begin
        eff_bank  = (svbk[BANK_BITS-1:0] == '0) ? BANK_BITS'(1) : svbk[BANK_BITS-1:0];
        wram_sel  = (bus.addr >= 16'hC000) && (bus.addr <= 16'hFDFF);
        wram_bank = bus.addr[12] ? eff_bank : '0;
        wram_idx  = {wram_bank, bus.addr[11:0]};
        svbk_sel  = (hram_bus.addr == 16'hFF70);
        hram_sel  = (hram_bus.addr[15:7] == 9'h1FF) && (32'(hram_bus.addr[6:0]) < HRAM_LEN);
        hram_idx  = HRAM_AW'(hram_bus.addr[6:0]);
    end

    assign unused_wdata_hi = ^hram_bus.wdata[7:3];

    // ---------------- fill sequencer ----------------
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RESET_STATE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (state == CLEAR && cnt != CNT_LAST)
                cnt <= cnt + CNT_W'(1);
        end
    end

    // NOTE: combinational blocks assign a default first so no path leaves a latch behind.
    always_comb begin
        state_next = state;
        if (state == CLEAR && cnt == CNT_LAST)
            state_next = IDLE;
    end

    always_comb begin
        busy      = (state == CLEAR);
        fill_hram = busy && (32'(cnt) < HRAM_LEN);
    end

    // SVBK stays writable during the fill; WRAM accesses this cycle still see the old value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            svbk <= 3'd0;
        else if (hram_bus.write_en && svbk_sel)
            svbk <= hram_bus.wdata[2:0];
    end

    // ---------------- memory write ports ----------------
    // NOTE: the arrays have no reset; clearing them is the sequencer's job.
    always_ff @(posedge clk) begin
        if (busy)
            wram[cnt] <= FILL_VALUE;
        else if (bus.write_en && wram_sel)
            wram[wram_idx] <= bus.wdata;
    end

    always_ff @(posedge clk) begin
        if (fill_hram)
            hram[HRAM_AW'(cnt)] <= FILL_VALUE;
        else if (!busy && hram_bus.write_en && hram_sel)
            hram[hram_idx] <= hram_bus.wdata;
    end

    // ---------------- zero-latency read ports ----------------
    always_comb begin
        bus.rdata = 8'hFF;
        if (bus.read_en && wram_sel && !busy)
            bus.rdata = wram[wram_idx];
    end

    always_comb begin
        hram_bus.rdata = 8'hFF;
        if (hram_bus.read_en) begin
            if (svbk_sel)
                hram_bus.rdata = {5'b11111, svbk};
            else if (hram_sel && !busy)
                hram_bus.rdata = hram[hram_idx];
        end
    end

endmodule
